// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: state encoding,
// opcode values and display-select codes.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_NUM1 = 3'd0,
        ST_NUM2 = 3'd1,
        ST_OP   = 3'd2,
        ST_EXEC = 3'd3,
        ST_SHOW = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] DISP_SWITCHES = 2'b00;
    localparam logic [1:0] DISP_OPCODE   = 2'b01;
    localparam logic [1:0] DISP_RESULT   = 2'b10;

    // Display source shown while sitting in a given state.
    function automatic logic [1:0] disp_for(input state_t s);
        logic [1:0] d;
        d = DISP_SWITCHES;
        case (s)
            ST_NUM1, ST_NUM2: d = DISP_SWITCHES;
            ST_OP, ST_EXEC:   d = DISP_OPCODE;
            ST_SHOW:          d = DISP_RESULT;
            default:          d = DISP_SWITCHES;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/calc_sequencer_exec_watchdog.sv
// EXEC-state watchdog: counts enabled cycles from a cleared start and flags the
// TIMEOUT_CYC-th cycle so the sequencer can abandon a hung ALU.
module exec_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted during the last allowed cycle, so the state leaves on the edge
    // that closes cycle TIMEOUT_CYC.
    assign expired = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: operand/opcode entry, ALU launch/completion and result
// display. Optional macro CALC_DIV0_TRAP_EN traps divide-by-zero before launch.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_pulse,
    input  logic              prev_pulse,
    input  logic [DATA_W-1:0] switches,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    output logic              alu_start,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        op_code,
    output logic [RES_W-1:0]  result,
    output logic [1:0]        disp_sel,
    output logic [2:0]        stage,
    output logic              error
);

    // ALU handshake: alu_start is a one-cycle launch pulse with no backpressure;
    // alu_done is a one-cycle pulse qualifying alu_result, honoured only in EXEC.

    state_t state;
    logic   next_only;
    logic   prev_only;
    logic   wd_expired;

    assign next_only = next_pulse & ~prev_pulse;
    assign prev_only = prev_pulse & ~next_pulse;
    assign stage     = state;

    exec_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != ST_EXEC),
        .enable (state == ST_EXEC),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_NUM1;
            operand_a <= '0;
            operand_b <= '0;
            op_code   <= OP_ADD;
            result    <= '0;
            alu_start <= 1'b0;
            error     <= 1'b0;
            disp_sel  <= DISP_SWITCHES;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ST_NUM1: begin
                    if (next_only) begin
                        operand_a <= switches;
                        state     <= ST_NUM2;
                        disp_sel  <= disp_for(ST_NUM2);
                    end
                end
                ST_NUM2: begin
                    if (next_only) begin
                        operand_b <= switches;
                        state     <= ST_OP;
                        disp_sel  <= disp_for(ST_OP);
                    end else if (prev_only) begin
                        state    <= ST_NUM1;
                        disp_sel <= disp_for(ST_NUM1);
                    end
                end
                ST_OP: begin
                    if (next_only) begin
                        op_code <= switches[1:0];
`ifdef CALC_DIV0_TRAP_EN
                        if (switches[1:0] == OP_DIV && operand_b == '0) begin
                            error    <= 1'b1;
                            result   <= '1;
                            state    <= ST_SHOW;
                            disp_sel <= disp_for(ST_SHOW);
                        end else begin
                            alu_start <= 1'b1;
                            state     <= ST_EXEC;
                            disp_sel  <= disp_for(ST_EXEC);
                        end
`else
                        alu_start <= 1'b1;
                        state     <= ST_EXEC;
                        disp_sel  <= disp_for(ST_EXEC);
`endif
                    end else if (prev_only) begin
                        state    <= ST_NUM2;
                        disp_sel <= disp_for(ST_NUM2);
                    end
                end
                ST_EXEC: begin
                    // A done arriving with the timeout still completes normally.
                    if (alu_done) begin
                        result   <= alu_result;
                        state    <= ST_SHOW;
                        disp_sel <= disp_for(ST_SHOW);
                    end else if (wd_expired) begin
                        error    <= 1'b1;
                        result   <= '0;
                        state    <= ST_SHOW;
                        disp_sel <= disp_for(ST_SHOW);
                    end
                end
                ST_SHOW: begin
                    if (next_only) begin
                        error    <= 1'b0;
                        state    <= ST_NUM1;
                        disp_sel <= disp_for(ST_NUM1);
                    end else if (prev_only) begin
                        state    <= ST_OP;
                        disp_sel <= disp_for(ST_OP);
                    end
                end
                default: begin
                    state    <= ST_NUM1;
                    disp_sel <= DISP_SWITCHES;
                end
            endcase
        end
    end

endmodule
